// File: rtl/alu_pkg.sv
// Shared definitions for the EX-stage ALU slice.
//   - 3-bit ALU control encodings driven by the control decoder
//   - multiply/divide engine FSM states
//   - default datapath width and iteration count
// Imported by alu_exec_unit and seq_muldiv_core.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned STEPS     = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_MULT = 3'b101;
    localparam logic [2:0] ALU_DIV  = 3'b110;
    localparam logic [2:0] ALU_RSVD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    function automatic logic is_muldiv(input logic [2:0] code);
        return (code == ALU_MULT) || (code == ALU_DIV);
    endfunction

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative signed multiply / divide engine, one bit per clock.
// Operands are reduced to magnitudes on accept; the sign of the result is
// applied on the final iteration, so hi/lo only ever change at completion.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   go          request a new operation (ignored while busy)
//   op_div      0 = MULT (shift-add), 1 = DIV (restoring)
//   a, b        signed operands (rs, rt)
//   busy        iterating; the pipeline must stall
//   done        one-cycle pulse, hi/lo hold the new result
//   hi, lo      MULT: {hi,lo} = product; DIV: lo = quotient, hi = remainder
module seq_muldiv_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STEPS - 1);

    md_state_e          state_q, state_d;
    logic               op_div_q;
    logic               sign_q;      // quotient / product sign
    logic               sign_r;      // remainder sign (follows dividend)
    logic [WIDTH-1:0]   mag_q;       // |a| for MULT (addend), |b| for DIV (divisor)
    logic [2*WIDTH-1:0] acc_q;       // MULT: {partial, multiplier}; DIV: {remainder, dividend/quotient}
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept;
    logic               div_zero;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        abs_a    = a[WIDTH-1] ? -a : a;
        abs_b    = b[WIDTH-1] ? -b : b;
        accept   = go && (state_q != ST_RUN);
        div_zero = op_div && (b == '0);

        // One iteration of either algorithm on the current accumulator.
        // The multiply carry is kept in a 33rd bit and shifted back in.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, mag_q};

        acc_step = acc_q;
        if (op_div_q) begin
            if (!div_diff[WIDTH]) begin
                acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_q[0]) begin
                acc_step = {mul_sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_step = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end

        prod_fix = sign_q ? -acc_step : acc_step;
        quot_fix = sign_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        rem_fix  = sign_r ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    // Divide by zero has a fixed answer; skip the iterations.
                    state_d = div_zero ? ST_DONE : ST_RUN;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_div_q <= 1'b0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            mag_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_div_q <= op_div;
                sign_q   <= a[WIDTH-1] ^ b[WIDTH-1];
                sign_r   <= a[WIDTH-1];
                cnt_q    <= CNT_LAST;
                mag_q    <= op_div ? abs_b : abs_a;
                acc_q    <= {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                if (div_zero) begin
                    hi_q <= a;
                    lo_q <= '1;
                end
            end else if (state_q == ST_RUN) begin
                acc_q <= acc_step;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    if (op_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: single-cycle ADD/SUB/AND/OR/SLT plus an iterative MULT/DIV
// engine writing architectural HI/LO.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        launches MULT/DIV when alu_control is 101/110
//   alu_control  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 MULT,
//                110 DIV, 111 reserved (behaves as ADD)
//   a, b         operands
//   result       combinational result; shows lo for MULT/DIV codes
//   zero         result == 0
//   busy         engine iterating, stall EX
//   done         one-cycle completion pulse
//   hi, lo       MULT product halves / DIV remainder and quotient
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic go;

    assign go = start && is_muldiv(alu_control);

    seq_muldiv_core #(
        .WIDTH (WIDTH),
        .STEPS (STEPS)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .op_div (alu_control == ALU_DIV),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always_comb begin
        result = a + b;
        case (alu_control)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_MULT: result = lo;
            ALU_DIV:  result = lo;
            default:  result = a + b;
        endcase
        zero = (result == '0);
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  alu_control;
    logic [31:0] a, b;
    logic [31:0] result, hi, lo;
    logic        zero, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;
    exp_t sb[$];

    alu_exec_unit #(.WIDTH(32), .STEPS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic is_div, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic signed [63:0] sx, sy, p;
        logic signed [31:0] dx, dy;
        if (!is_div) begin
            sx = $signed(x);
            sy = $signed(y);
            p  = sx * sy;
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 32'h0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            e.hi = 32'h0;
            e.lo = 32'h8000_0000;
        end else begin
            dx = $signed(x);
            dy = $signed(y);
            e.lo = dx / dy;
            e.hi = dx % dy;
        end
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one MULT/DIV request for one cycle and record its expected result.
    // Returns in cycle 1 of the operation.
    task automatic issue(input logic [2:0] code, input logic [31:0] x, input logic [31:0] y);
        alu_control = code;
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(model(code == ALU_DIV, x, y));
        tick();
        start = 1'b0;
    endtask

    // Wait for done starting at cycle 'first'; n = cycle done seen (-1 on timeout).
    // bad counts waiting cycles where busy was low or hi/lo moved.
    task automatic wait_done(input int first, output int n, output int bad);
        logic [31:0] hi0, lo0;
        hi0 = hi;
        lo0 = lo;
        bad = 0;
        n = first;
        while (!done && n < 40) begin
            if (!busy || hi !== hi0 || lo !== lo0) bad++;
            tick();
            n++;
        end
        if (!done) n = -1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        alu_control = ALU_ADD;
        a = '0;
        b = '0;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
        end
        checks++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL reset_result result=%h zero=%b expected 0 1", result, zero);
        end
    endtask

    typedef struct {
        logic [2:0]  c;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic        z;
    } cv_t;

    task automatic test_comb;
        cv_t tab[9];
        tab[0] = '{ALU_ADD,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0};
        tab[1] = '{ALU_SUB,  32'h5,         32'h5,         32'h0,         1'b1};
        tab[2] = '{ALU_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
        tab[3] = '{ALU_SLT,  32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1};
        tab[4] = '{ALU_SLT,  32'h8000_0000, 32'h7FFF_FFFF, 32'h1,         1'b0};
        tab[5] = '{ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
        tab[6] = '{ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
        tab[7] = '{ALU_RSVD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        tab[8] = '{ALU_SUB,  32'h0,         32'h1,         32'hFFFF_FFFF, 1'b0};
        foreach (tab[i]) begin
            alu_control = tab[i].c;
            a = tab[i].x;
            b = tab[i].y;
            #1;
            checks++;
            if (result !== tab[i].r || zero !== tab[i].z) begin
                errors++;
                $display("FAIL comb_%0d ctl=%b result=%h zero=%b expected %h %b",
                         i, tab[i].c, result, zero, tab[i].r, tab[i].z);
            end
        end
        // start with a single-cycle code must not launch the engine
        alu_control = ALU_ADD;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0) begin
            errors++;
            $display("FAIL comb_start_ignored busy=%b done=%b hi=%h expected 0 0 0", busy, done, hi);
        end
    endtask

    // Common tail: check latency, stability, and scoreboard entry.
    task automatic test_mult;
        int n, bad;
        exp_t e;
        issue(ALU_MULT, -32'sd3, 32'sd7);
        wait_done(1, n, bad);
        checks++;
        if (n !== 33) begin
            errors++;
            $display("FAIL mult_latency done_cycle=%0d expected 33", n);
        end
        checks++;
        if (bad !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mult_busy bad_cycles=%0d busy_at_done=%b expected 0 0", bad, busy);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo || result !== e.lo) begin
            errors++;
            $display("FAIL mult_hilo hi=%h lo=%h result=%h expected hi=%h lo=%h", hi, lo, result, e.hi, e.lo);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL mult_done_pulse done=%b expected 0", done);
        end
    endtask

    task automatic test_div;
        int n, bad;
        exp_t e;
        issue(ALU_DIV, -32'sd7, 32'sd2);
        wait_done(1, n, bad);
        checks++;
        if (n !== 33 || bad !== 0) begin
            errors++;
            $display("FAIL div_latency done_cycle=%0d bad_cycles=%0d expected 33 0", n, bad);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL div_hilo hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
        tick();
    endtask

    task automatic test_div_edges;
        int n, bad;
        exp_t e;
        issue(ALU_DIV, 32'h1234, 32'h0);
        wait_done(1, n, bad);
        checks++;
        if (n !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL divzero_latency done_cycle=%0d busy=%b expected 1 0", n, busy);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL divzero_hilo hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
        tick();
        issue(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, n, bad);
        checks++;
        if (n !== 33 || bad !== 0) begin
            errors++;
            $display("FAIL divovf_latency done_cycle=%0d bad_cycles=%0d expected 33 0", n, bad);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL divovf_hilo hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        int n, bad, pulses;
        exp_t e;
        issue(ALU_MULT, 32'h0001_2345, 32'h0000_6789);
        for (int c = 1; c < 10; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        void'(sb.pop_back());
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h expected 0 0 0 0", busy, done, hi, lo);
        end
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (done || busy) pulses++;
            tick();
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_quiet active_cycles=%0d expected 0", pulses);
        end
        issue(ALU_MULT, 32'd6, 32'd7);
        wait_done(1, n, bad);
        e = sb.pop_front();
        checks++;
        if (n !== 33 || lo !== e.lo || hi !== e.hi) begin
            errors++;
            $display("FAIL reset_mid_mult done_cycle=%0d hi=%h lo=%h expected 33 %h %h", n, hi, lo, e.hi, e.lo);
        end
        tick();
    endtask

    task automatic test_busy_start;
        int n, bad;
        exp_t e;
        issue(ALU_MULT, 32'h0001_2345, -32'sd77);
        for (int c = 1; c < 5; c++) tick();
        alu_control = ALU_DIV;
        a = 32'd100;
        b = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        alu_control = ALU_MULT;
        wait_done(6, n, bad);
        checks++;
        if (n !== 33 || bad !== 0) begin
            errors++;
            $display("FAIL busy_start_latency done_cycle=%0d bad_cycles=%0d expected 33 0", n, bad);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL busy_start_hilo hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
    endtask

    // Entered in a DONE cycle left by test_busy_start.
    task automatic test_back_to_back;
        int n, bad;
        exp_t e;
        issue(ALU_DIV, 32'h7FFF_FFFF, 32'h10);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept done=%b busy=%b expected 0 1", done, busy);
        end
        wait_done(1, n, bad);
        checks++;
        if (n !== 33 || bad !== 0) begin
            errors++;
            $display("FAIL b2b_latency done_cycle=%0d bad_cycles=%0d expected 33 0", n, bad);
        end
        e = sb.pop_front();
        checks++;
        if (hi !== e.hi || lo !== e.lo) begin
            errors++;
            $display("FAIL b2b_hilo hi=%h lo=%h expected hi=%h lo=%h", hi, lo, e.hi, e.lo);
        end
        tick();
    endtask

    task automatic test_random;
        int n, bad;
        exp_t e;
        logic [31:0] x, y;
        logic [2:0] code;
        for (int k = 0; k < 6; k++) begin
            x = $urandom;
            y = (k == 0) ? 32'h8000_0000 : $urandom;
            if (k == 0) x = 32'h8000_0000;
            if (k == 5) y = 32'h0000_0003;
            code = k[0] ? ALU_DIV : ALU_MULT;
            issue(code, x, y);
            wait_done(1, n, bad);
            e = sb.pop_front();
            checks++;
            if (n !== 33 || hi !== e.hi || lo !== e.lo) begin
                errors++;
                $display("FAIL rand_%0d ctl=%b a=%h b=%h done_cycle=%0d hi=%h lo=%h expected 33 %h %h",
                         k, code, x, y, n, hi, lo, e.hi, e.lo);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        alu_control = ALU_ADD;
        a = '0;
        b = '0;
        test_reset();
        test_comb();
        test_mult();
        test_div();
        test_div_edges();
        test_reset_mid();
        test_busy_start();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
